// File: rtl/logicnet_input_quantizer_if.sv
// Stream bundle between the raw-feature source, the quantizer and the
// layer-0 neuron bank.
//   s_valid/s_ready/s_data/s_last : raw signed feature beats, one per feature
//   m_valid/m_ready/m_data        : one packed code vector per sample
// slave  : the quantizer's view (consumes s_*, produces m_*)
// master : the environment's view (produces s_*, consumes m_*)
interface logicnet_input_quantizer_if #(
   parameter int NUM_FEATURES = 49,
   parameter int FEAT_W       = 16
);
   logic                      s_valid;
   logic                      s_ready;
   logic [FEAT_W-1:0]         s_data;
   logic                      s_last;
   logic                      m_valid;
   logic                      m_ready;
   logic [2*NUM_FEATURES-1:0] m_data;

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_data
   );

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_data
   );
endinterface

// File: rtl/logicnet_input_quantizer.sv
// LogicNets input quantizer. Each accepted raw feature is compared against
// three programmable signed thresholds for its feature slot; the number of
// thresholds it meets or exceeds (0..3) is packed into a per-sample vector
// that is handed to layer 0 once the sample is complete. Samples whose
// s_last does not line up with the last feature are dropped and flagged.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream bundle (slave side), see logicnet_input_quantizer_if
//   cfg_we     : threshold write strobe
//   cfg_addr   : threshold index 3*f+k; out-of-range addresses are ignored
//   cfg_data   : signed threshold value
//   err_len    : one-cycle pulse when a sample is dropped for bad framing
module logicnet_input_quantizer #(
   parameter int NUM_FEATURES = 49,
   parameter int FEAT_W       = 16,
   parameter int QBITS        = 2,
   localparam int AW          = $clog2(3*NUM_FEATURES),
   localparam int IW          = $clog2(NUM_FEATURES)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   logicnet_input_quantizer_if.slave     bus,
   input  logic                          cfg_we,
   input  logic [AW-1:0]                 cfg_addr,
   input  logic [FEAT_W-1:0]             cfg_data,
   output logic                          err_len
);

   localparam logic [1:0] ST_COLLECT = 2'd0;
   localparam logic [1:0] ST_HOLD    = 2'd1;
   localparam logic [1:0] ST_DROP    = 2'd2;

   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_FEATURES-1);

   logic signed [FEAT_W-1:0]             thr_q [NUM_FEATURES][3];
   logic [NUM_FEATURES-1:0][QBITS-1:0]   pack_q, pack_d;
   logic [1:0]                           state_q, state_d;
   logic [IW-1:0]                        idx_q, idx_d;
   logic                                 err_q, err_d;
   logic                                 live_q;
   logic signed [FEAT_W-1:0]             din;
   logic [QBITS-1:0]                     code;
   logic                                 acc;

   // Threshold store: address decode by comparison, so addresses past the
   // last threshold simply match nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int f = 0; f < NUM_FEATURES; f++)
            for (int k = 0; k < 3; k++)
               thr_q[f][k] <= '0;
      end else begin
         for (int f = 0; f < NUM_FEATURES; f++)
            for (int k = 0; k < 3; k++)
               if (cfg_we && cfg_addr == AW'(3*f + k))
                  thr_q[f][k] <= cfg_data;
      end
   end

   // Thermometer count against the current (pre-write) thresholds; the
   // thresholds are unordered so each comparison contributes independently.
   assign din = bus.s_data;
   always_comb begin
      code = '0;
      for (int k = 0; k < 3; k++)
         if (din >= thr_q[idx_q][k])
            code = code + 1'b1;
   end

   // s_ready stays low through reset and comes up on the first clock after.
   assign acc         = bus.s_valid && bus.s_ready;
   assign bus.s_ready = live_q && (state_q != ST_HOLD);
   assign bus.m_valid = (state_q == ST_HOLD);
   assign bus.m_data  = pack_q;
   assign err_len     = err_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pack_d  = pack_q;
      err_d   = 1'b0;
      case (state_q)
         ST_COLLECT: begin
            if (acc) begin
               // Storing on a framing error is harmless: the next good
               // sample overwrites every slot before it is presented.
               pack_d[idx_q] = code;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = bus.s_last ? ST_HOLD : ST_DROP;
                  err_d   = !bus.s_last;
               end else if (bus.s_last) begin
                  idx_d = '0;
                  err_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (bus.m_ready)
               state_d = ST_COLLECT;
         end
         ST_DROP: begin
            if (acc && bus.s_last)
               state_d = ST_COLLECT;
         end
         default: state_d = ST_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_COLLECT;
         idx_q   <= '0;
         pack_q  <= '0;
         err_q   <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pack_q  <= pack_d;
         err_q   <= err_d;
         live_q  <= 1'b1;
      end
   end

endmodule

// File: doc/logicnet_input_quantizer.md
# logicnet_input_quantizer

Front-end stage of the LogicNets classifier that feeds the layer-0 neuron bank. It accepts raw signed feature words one per beat over a valid/ready stream and quantizes each into a 2-bit thermometer-count code against three programmable per-feature thresholds. It packs a complete sample into one flat vector and presents that vector to layer 0 with a valid/ready handshake. It also detects malformed sample framing and drops those samples.

## Interface

Parameters:
- NUM_FEATURES, 49, features per sample (≥2).
- FEAT_W, 16, raw feature width, two's-complement signed.
- QBITS, 2, code width per feature; fixed at 2 (three thresholds).

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  raw feature beat valid.
- s_ready  out  1  block accepts a beat when s_valid && s_ready.
- s_data  in  FEAT_W  raw feature value, signed.
- s_last  in  1  marks the final feature of a sample.
- cfg_we  in  1  threshold write strobe.
- cfg_addr  in  clog2(3*NUM_FEATURES)  threshold index = 3*f + k, with k in 0..2.
- cfg_data  in  FEAT_W  threshold value, signed.
- m_valid  out  1  packed sample valid.
- m_ready  in  1  layer-0 bank accepts the packed sample.
- m_data  out  2*NUM_FEATURES  packed codes; feature f is at bits [2f+1:2f].
- err_len  out  1  one-cycle pulse when a sample is dropped for framing error.

## Operation

- Threshold store: 3*NUM_FEATURES registers of FEAT_W bits, all reset to 0.
  - A cfg_we write updates the addressed register at the clock edge.
  - cfg_addr ≥ 3*NUM_FEATURES: the write is ignored.
  - Writes are legal in any state.
- Quantization of an accepted beat for feature f = idx:
  - code = (s_data ≥ T[f][0]) + (s_data ≥ T[f][1]) + (s_data ≥ T[f][2]).
  - All comparisons are signed. Thresholds need not be ordered; the code is always a count in 0..3.
  - A beat accepted in the same cycle as a write to its threshold uses the old threshold value.
- Feature counter idx runs 0..NUM_FEATURES-1 and resets to 0.
- Each accepted code is written into a pack register at bits [2idx+1:2idx]. m_data is driven from this register.
- FSM states: COLLECT (reset state), HOLD, DROP.
  - COLLECT: s_ready=1, m_valid=0. On each accepted beat:
    - idx<N-1 and s_last=0: store the code, idx++.
    - idx<N-1 and s_last=1: early last. Pulse err_len, set idx=0, stay in COLLECT. Pack contents are don't-care until overwritten.
    - idx=N-1 and s_last=1: store the code, set idx=0, go to HOLD.
    - idx=N-1 and s_last=0: missing last. Pulse err_len, set idx=0, go to DROP.
  - HOLD: s_ready=0, m_valid=1, m_data held stable. When m_ready=1, go to COLLECT.
  - DROP: s_ready=1. Accepted beats are discarded. When a beat with s_last=1 is accepted, go to COLLECT. No further err_len pulses occur in DROP.
- err_len is registered and goes high the cycle after the offending beat, for exactly one cycle.

## Timing

- Reset values: s_ready=0 while rst_n=0 (1 from the first clock after release), m_valid=0, m_data=0, err_len=0, idx=0, state=COLLECT.
- Latency: if the final beat is accepted at edge t, m_valid=1 is visible from t onward (registered). m_data is complete in the same cycle.
- Handshake: m_valid holds with m_data stable until m_ready is sampled high. m_valid drops on the edge that completes the transfer.
- s_ready returns to 1 one cycle after the output transfer. Minimum period is NUM_FEATURES+1 cycles per sample.
- s_valid with s_ready=0 is not accepted, and the source must hold the beat.
- If rst_n is asserted mid-sample or in HOLD, the partial or held sample is lost and thresholds return to 0.

## Test plan

- Thresholds at reset are all 0. With N=3, beats {-1, 0, 5} then last → m_data=6'b111100; m_valid rises the cycle after the last beat.
- N=3, feature 1 thresholds {-10, 0, 10}, beats {x, -20, y} → bits [3:2]=00. Beat 15 → 11, beat 0 → 10, beat -10 → 01.
- HOLD backpressure: m_ready low for 5 cycles → m_valid stays 1, m_data unchanged, s_ready=0. Raise m_ready → transfer, s_ready=1 on the next cycle.
- Early last: N=3, s_last on the 2nd beat → one err_len pulse, no m_valid. A following well-formed sample is output correctly.
- Missing last: 5-beat sample with last on the 5th beat → err_len once after beat 3, beats 4–5 discarded, next sample correct.
- Threshold write in the same cycle as a beat for that feature → the beat uses the old threshold; the next sample uses the new one. A cfg_addr=3N write has no effect.
